// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the branch resolution unit: register width, comparator
// op encodings, request kinds, pipeline state and the registered result payload.
package branch_resolve_pkg;

  localparam int unsigned REG_W = 32;
  localparam int unsigned CNT_W = 32;

  typedef enum logic [2:0] {
    COM_OP_EQ   = 3'd0,
    COM_OP_NE   = 3'd1,
    COM_OP_LT   = 3'd2,
    COM_OP_GE   = 3'd3,
    COM_OP_LTU  = 3'd4,
    COM_OP_GEU  = 3'd5,
    COM_OP_ONE  = 3'd6,
    COM_OP_NONE = 3'd7
  } com_op_e;

  typedef enum logic [1:0] {
    KIND_BRANCH = 2'd0,
    KIND_JAL    = 2'd1,
    KIND_JALR   = 2'd2,
    KIND_RSVD   = 2'd3
  } req_kind_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  typedef struct packed {
    logic             taken;
    logic             misalign;
    logic [REG_W-1:0] target;
    logic [REG_W-1:0] link;
  } rsp_t;

  // Undefined funct3 codes and the reserved kind map to an op that never fires.
  function automatic com_op_e decode_op(input req_kind_e kind, input logic [2:0] funct3);
    com_op_e op;
    op = COM_OP_NONE;
    case (kind)
      KIND_BRANCH: begin
        case (funct3)
          3'b000:  op = COM_OP_EQ;
          3'b001:  op = COM_OP_NE;
          3'b100:  op = COM_OP_LT;
          3'b101:  op = COM_OP_GE;
          3'b110:  op = COM_OP_LTU;
          3'b111:  op = COM_OP_GEU;
          default: op = COM_OP_NONE;
        endcase
      end
      KIND_JAL, KIND_JALR: op = COM_OP_ONE;
      default:             op = COM_OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/branch_resolve_com.sv
// Operand comparator: evaluates one COM_OP_* condition on two register values.
module branch_resolve_com
  import branch_resolve_pkg::*;
#(
  parameter int unsigned W = REG_W
) (
  input  com_op_e      op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         result_c
);

  always_comb begin
    result_c = 1'b0;
    case (op)
      COM_OP_EQ:   result_c = (a == b);
      COM_OP_NE:   result_c = (a != b);
      COM_OP_LT:   result_c = ($signed(a) <  $signed(b));
      COM_OP_GE:   result_c = ($signed(a) >= $signed(b));
      COM_OP_LTU:  result_c = (a <  b);
      COM_OP_GEU:  result_c = (a >= b);
      COM_OP_ONE:  result_c = 1'b1;
      default:     result_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// One-entry branch/jump resolution stage with valid/ready handshakes and a taken counter.
// Optional feature: define BRANCH_RESOLVE_MISALIGN_EN to flag taken targets with bit 1 set.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int unsigned XLEN = REG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_kind,
  input  logic [2:0]       req_funct3,
  input  logic [XLEN-1:0]  req_pc,
  input  logic [XLEN-1:0]  req_imm,
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_taken,
  output logic [XLEN-1:0]  rsp_target,
  output logic [XLEN-1:0]  rsp_link,
  output logic             rsp_misalign,
  output logic [CNT_W-1:0] taken_cnt
);

  state_e          state;
  state_e          state_nxt;
  rsp_t            rsp_q;
  rsp_t            res_c;
  req_kind_e       kind_c;
  com_op_e         op_c;
  logic            cmp_c;
  logic            accept_c;
  logic            rsp_hs_c;
  logic            load_c;
  logic            cnt_inc_c;
  logic [XLEN-1:0] pc_sum_c;
  logic [XLEN-1:0] rs_sum_c;
  logic [XLEN-1:0] tgt_c;
  logic [CNT_W-1:0] cnt_q;

  assign kind_c = req_kind_e'(req_kind);
  assign op_c   = decode_op(kind_c, req_funct3);

  branch_resolve_com #(.W(XLEN)) u_com (
    .op       (op_c),
    .a        (req_rs1),
    .b        (req_rs2),
    .result_c (cmp_c)
  );

  // Result for the request currently on the bus; JALR targets are halfword aligned.
  always_comb begin
    pc_sum_c = req_pc + req_imm;
    rs_sum_c = req_rs1 + req_imm;
    tgt_c    = pc_sum_c;
    if (kind_c == KIND_JALR) begin
      tgt_c = {rs_sum_c[XLEN-1:1], 1'b0};
    end
    res_c        = '0;
    res_c.taken  = cmp_c;
    res_c.target = REG_W'(tgt_c);
    res_c.link   = REG_W'(req_pc + XLEN'(4));
`ifdef BRANCH_RESOLVE_MISALIGN_EN
    res_c.misalign = cmp_c & tgt_c[1];
`else
    res_c.misalign = 1'b0;
`endif
  end

  // Flush wins over both handshakes: nothing is accepted and the held entry is not counted.
  assign req_ready = !flush && ((state == ST_EMPTY) || rsp_ready);
  assign accept_c  = req_valid && req_ready;
  assign rsp_hs_c  = (state == ST_FULL) && rsp_ready && !flush;
  assign cnt_inc_c = rsp_hs_c && rsp_q.taken && !rsp_q.misalign;

  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else if (accept_c) begin
      state_nxt = ST_FULL;
      load_c    = 1'b1;
    end else if (rsp_hs_c) begin
      state_nxt = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
      rsp_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      if (load_c) begin
        rsp_q <= res_c;
      end
      if (cnt_inc_c) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign rsp_valid    = (state == ST_FULL);
  assign rsp_taken    = rsp_q.taken;
  assign rsp_misalign = rsp_q.misalign;
  assign rsp_target   = XLEN'(rsp_q.target);
  assign rsp_link     = XLEN'(rsp_q.link);
  assign taken_cnt    = cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_kind;
  logic [2:0]  req_funct3;
  logic [31:0] req_pc, req_imm, req_rs1, req_rs2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_taken;
  logic [31:0] rsp_target, rsp_link;
  logic        rsp_misalign;
  logic [31:0] taken_cnt;

  int unsigned check_cnt = 0;
  int unsigned pass_cnt  = 0;

  // Reference model: the single held response and the expected counter.
  logic        mv, mt, mm;
  logic [1:0]  mkind;
  logic [31:0] mtgt, mlink, mcnt;
  logic        obs_rdy, exp_rdy;

`ifdef BRANCH_RESOLVE_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  branch_resolve #(.XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_kind     (req_kind),
    .req_funct3   (req_funct3),
    .req_pc       (req_pc),
    .req_imm      (req_imm),
    .req_rs1      (req_rs1),
    .req_rs2      (req_rs2),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_taken    (rsp_taken),
    .rsp_target   (rsp_target),
    .rsp_link     (rsp_link),
    .rsp_misalign (rsp_misalign),
    .taken_cnt    (taken_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void ref_resolve(input logic [1:0] k, input logic [2:0] f3,
                                      input logic [31:0] pc, input logic [31:0] imm,
                                      input logic [31:0] rs1, input logic [31:0] rs2,
                                      output logic t, output logic m,
                                      output logic [31:0] tg, output logic [31:0] lk);
    int signed s1, s2;
    s1 = rs1;
    s2 = rs2;
    t  = 1'b0;
    tg = pc + imm;
    if (k == 2'd0) begin
      case (f3)
        3'd0: t = (rs1 == rs2);
        3'd1: t = (rs1 != rs2);
        3'd4: t = (s1 < s2);
        3'd5: t = (s1 >= s2);
        3'd6: t = (rs1 < rs2);
        3'd7: t = (rs1 >= rs2);
        default: t = 1'b0;
      endcase
    end else if (k == 2'd1) begin
      t = 1'b1;
    end else if (k == 2'd2) begin
      t  = 1'b1;
      tg = (rs1 + imm) & 32'hFFFF_FFFE;
    end
    lk = pc + 32'd4;
    m  = MIS_EN && t && tg[1];
  endfunction

  // Drive one cycle from just after a falling edge, advance the model, return at the next falling edge.
  task automatic drive_cycle(input logic v, input logic [1:0] k, input logic [2:0] f3,
                             input logic [31:0] pc, input logic [31:0] imm,
                             input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic rr, input logic fl);
    logic t, m, hs, acc;
    logic [31:0] tg, lk;
    ref_resolve(k, f3, pc, imm, rs1, rs2, t, m, tg, lk);
    req_valid = v; req_kind = k; req_funct3 = f3;
    req_pc = pc; req_imm = imm; req_rs1 = rs1; req_rs2 = rs2;
    rsp_ready = rr; flush = fl;
    #1;
    obs_rdy = req_ready;
    exp_rdy = !fl && (!mv || rr);
    @(posedge clk);
    hs  = mv && rr && !fl;
    acc = v && exp_rdy;
    if (hs && mt && !mm) mcnt = mcnt + 32'd1;
    if (fl) mv = 1'b0;
    else if (acc) begin
      mv = 1'b1; mt = t; mm = m; mtgt = tg; mlink = lk; mkind = k;
    end else if (hs) mv = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input logic rr);
    drive_cycle(1'b0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, rr, 1'b0);
  endtask

  task automatic model_reset();
    mv = 1'b0; mt = 1'b0; mm = 1'b0; mkind = 2'd0;
    mtgt = '0; mlink = '0; mcnt = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_kind = 2'd0; req_funct3 = 3'd0;
    req_pc = '0; req_imm = '0; req_rs1 = '0; req_rs2 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_cnt++;
    if ({rsp_valid, rsp_taken, rsp_misalign} !== 3'b000 || rsp_target !== 32'h0 ||
        rsp_link !== 32'h0 || taken_cnt !== 32'h0)
      $display("FAIL reset_state: valid=%b taken=%b mis=%b tgt=%h link=%h cnt=%h, required all zero",
               rsp_valid, rsp_taken, rsp_misalign, rsp_target, rsp_link, taken_cnt);
    else pass_cnt++;
    check_cnt++;
    if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", req_ready);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_branch_eq();
    drive_cycle(1'b1, 2'd0, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b1, 1'b0);
    check_cnt++;
    if (obs_rdy !== 1'b1) $display("FAIL beq_ready: got %b required 1", obs_rdy);
    else pass_cnt++;
    check_cnt++;
    if (rsp_valid !== 1'b1 || rsp_taken !== 1'b1 || rsp_target !== 32'h120 || rsp_link !== 32'h104)
      $display("FAIL beq_result: valid=%b taken=%b tgt=%h link=%h, required 1 1 00000120 00000104",
               rsp_valid, rsp_taken, rsp_target, rsp_link);
    else pass_cnt++;
    idle(1'b1);
    check_cnt++;
    if (rsp_valid !== 1'b0 || taken_cnt !== 32'd1)
      $display("FAIL beq_drain: valid=%b cnt=%0d, required 0 1", rsp_valid, taken_cnt);
    else pass_cnt++;
  endtask

  task automatic test_signed_unsigned();
    drive_cycle(1'b1, 2'd0, 3'b100, 32'h40, 32'h8, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
    check_cnt++;
    if (rsp_valid !== 1'b1 || rsp_taken !== 1'b1)
      $display("FAIL blt_signed: valid=%b taken=%b, required 1 1", rsp_valid, rsp_taken);
    else pass_cnt++;
    drive_cycle(1'b1, 2'd0, 3'b110, 32'h40, 32'h8, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
    check_cnt++;
    if (rsp_valid !== 1'b1 || rsp_taken !== 1'b0)
      $display("FAIL bltu_unsigned: valid=%b taken=%b, required 1 0", rsp_valid, rsp_taken);
    else pass_cnt++;
    idle(1'b1);
    check_cnt++;
    if (taken_cnt !== mcnt) $display("FAIL cmp_count: got %0d required %0d", taken_cnt, mcnt);
    else pass_cnt++;
  endtask

  task automatic test_jalr();
    logic [31:0] c1;
    drive_cycle(1'b1, 2'd2, 3'd0, 32'h500, 32'h4, 32'h1001, 32'h0, 1'b1, 1'b0);
    check_cnt++;
    if (rsp_taken !== 1'b1 || rsp_target !== 32'h1004 || rsp_link !== 32'h504)
      $display("FAIL jalr_target: taken=%b tgt=%h link=%h, required 1 00001004 00000504",
               rsp_taken, rsp_target, rsp_link);
    else pass_cnt++;
    drive_cycle(1'b1, 2'd2, 3'd0, 32'h600, 32'h0, 32'h1002, 32'h0, 1'b1, 1'b0);
    c1 = mcnt;
    check_cnt++;
    if (rsp_taken !== 1'b1 || rsp_target !== 32'h1002 || rsp_misalign !== MIS_EN)
      $display("FAIL jalr_misalign: taken=%b tgt=%h mis=%b, required 1 00001002 %b",
               rsp_taken, rsp_target, rsp_misalign, MIS_EN);
    else pass_cnt++;
    idle(1'b1);
    check_cnt++;
    if (taken_cnt !== (MIS_EN ? c1 : c1 + 32'd1))
      $display("FAIL misalign_count: got %0d required %0d", taken_cnt, MIS_EN ? c1 : c1 + 32'd1);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    drive_cycle(1'b1, 2'd1, 3'd0, 32'h200, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 2'd1, 3'd0, 32'h900, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0);
      check_cnt++;
      if (obs_rdy !== 1'b0 || rsp_valid !== 1'b1 || rsp_taken !== 1'b1 ||
          rsp_target !== 32'h240 || rsp_link !== 32'h204)
        $display("FAIL stall_hold[%0d]: rdy=%b valid=%b taken=%b tgt=%h link=%h, required 0 1 1 00000240 00000204",
                 i, obs_rdy, rsp_valid, rsp_taken, rsp_target, rsp_link);
      else pass_cnt++;
    end
    drive_cycle(1'b1, 2'd1, 3'd0, 32'h300, 32'h8, 32'h0, 32'h0, 1'b1, 1'b0);
    check_cnt++;
    if (obs_rdy !== 1'b1 || rsp_valid !== 1'b1 || rsp_target !== 32'h308 || rsp_link !== 32'h304)
      $display("FAIL b2b_first: rdy=%b valid=%b tgt=%h link=%h, required 1 1 00000308 00000304",
               obs_rdy, rsp_valid, rsp_target, rsp_link);
    else pass_cnt++;
    drive_cycle(1'b1, 2'd0, 3'b001, 32'h400, 32'hFFFF_FFF8, 32'd1, 32'd2, 1'b1, 1'b0);
    check_cnt++;
    if (rsp_valid !== 1'b1 || rsp_taken !== 1'b1 || rsp_target !== 32'h3F8)
      $display("FAIL b2b_second: valid=%b taken=%b tgt=%h, required 1 1 000003f8",
               rsp_valid, rsp_taken, rsp_target);
    else pass_cnt++;
    idle(1'b1);
    check_cnt++;
    if (rsp_valid !== 1'b0 || taken_cnt !== mcnt)
      $display("FAIL b2b_count: valid=%b cnt=%0d, required 0 %0d", rsp_valid, taken_cnt, mcnt);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    logic [31:0] c0;
    drive_cycle(1'b1, 2'd1, 3'd0, 32'h700, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0);
    c0 = mcnt;
    drive_cycle(1'b1, 2'd1, 3'd0, 32'h800, 32'h20, 32'h0, 32'h0, 1'b1, 1'b1);
    check_cnt++;
    if (obs_rdy !== 1'b0) $display("FAIL flush_ready: got %b required 0", obs_rdy);
    else pass_cnt++;
    check_cnt++;
    if (rsp_valid !== 1'b0 || taken_cnt !== c0)
      $display("FAIL flush_drop: valid=%b cnt=%0d, required 0 %0d", rsp_valid, taken_cnt, c0);
    else pass_cnt++;
    drive_cycle(1'b1, 2'd0, 3'b010, 32'h10, 32'h4, 32'h0, 32'h0, 1'b1, 1'b0);
    check_cnt++;
    if (rsp_valid !== 1'b1 || rsp_taken !== 1'b0)
      $display("FAIL funct3_010: valid=%b taken=%b, required 1 0", rsp_valid, rsp_taken);
    else pass_cnt++;
    drive_cycle(1'b1, 2'd3, 3'b000, 32'h10, 32'h4, 32'h0, 32'h0, 1'b1, 1'b0);
    check_cnt++;
    if (rsp_valid !== 1'b1 || rsp_taken !== 1'b0)
      $display("FAIL reserved_kind: valid=%b taken=%b, required 1 0", rsp_valid, rsp_taken);
    else pass_cnt++;
    idle(1'b1);
  endtask

  task automatic test_random();
    logic v, rr, fl;
    logic [1:0] k;
    logic [2:0] f3;
    logic [31:0] pc, imm, rs1, rs2;
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 9) < 7);
      rr  = ($urandom_range(0, 9) < 6);
      fl  = ($urandom_range(0, 19) == 0);
      k   = 2'($urandom_range(0, 3));
      f3  = 3'($urandom_range(0, 7));
      pc  = $urandom & 32'hFFFF_FFFC;
      imm = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 15));
      rs1 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
      rs2 = ($urandom_range(0, 2) == 0) ? rs1 : $urandom;
      drive_cycle(v, k, f3, pc, imm, rs1, rs2, rr, fl);
      check_cnt++;
      if (obs_rdy !== exp_rdy) $display("FAIL rand_ready[%0d]: got %b required %b", i, obs_rdy, exp_rdy);
      else pass_cnt++;
      check_cnt++;
      if (rsp_valid !== mv || taken_cnt !== mcnt ||
          (mv && (rsp_taken !== mt || rsp_misalign !== mm || rsp_link !== mlink ||
                  (mkind != 2'd3 && rsp_target !== mtgt))))
        $display("FAIL rand_rsp[%0d]: valid=%b taken=%b mis=%b tgt=%h link=%h cnt=%0d, required %b %b %b %h %h %0d",
                 i, rsp_valid, rsp_taken, rsp_misalign, rsp_target, rsp_link, taken_cnt,
                 mv, mt, mm, mtgt, mlink, mcnt);
      else pass_cnt++;
    end
    idle(1'b1);
  endtask

  task automatic test_wrap();
    drive_cycle(1'b1, 2'd1, 3'd0, 32'h1000, 32'h100, 32'h0, 32'h0, 1'b1, 1'b0);
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    mcnt = 32'hFFFF_FFFF;
    idle(1'b1);
    check_cnt++;
    if (taken_cnt !== 32'h0) $display("FAIL cnt_wrap: got %h required 00000000", taken_cnt);
    else pass_cnt++;
    drive_cycle(1'b1, 2'd1, 3'd0, 32'h1000, 32'h100, 32'h0, 32'h0, 1'b1, 1'b0);
    idle(1'b1);
    check_cnt++;
    if (taken_cnt !== 32'h1) $display("FAIL cnt_after_wrap: got %h required 00000001", taken_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    drive_cycle(1'b1, 2'd1, 3'd0, 32'h2000, 32'h8, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_cnt++;
    if (rsp_valid !== 1'b0 || rsp_taken !== 1'b0 || rsp_target !== 32'h0 || taken_cnt !== 32'h0)
      $display("FAIL reset_mid: valid=%b taken=%b tgt=%h cnt=%0d, required 0 0 00000000 0",
               rsp_valid, rsp_taken, rsp_target, taken_cnt);
    else pass_cnt++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1);
    check_cnt++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL reset_recover: valid=%b rdy=%b, required 0 1", rsp_valid, req_ready);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_branch_eq();
    test_signed_unsigned();
    test_jalr();
    test_back_to_back();
    test_flush();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the register, PC and immediate width; it SHALL equal the shared register width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port flush, input, 1, which drops any held result.
REQ-005 SHALL have port req_valid, input, 1, and port req_ready, output, 1, forming the request handshake.
REQ-006 SHALL have port req_kind, input, 2: 0=BRANCH, 1=JAL, 2=JALR, 3=reserved.
REQ-007 SHALL have port req_funct3, input, 3, the branch condition field.
REQ-008 SHALL have ports req_pc, req_imm, req_rs1 and req_rs2, each input, XLEN.
REQ-009 SHALL have port rsp_valid, output, 1, and port rsp_ready, input, 1, forming the response handshake.
REQ-010 SHALL have port rsp_taken, output, 1, the redirect decision.
REQ-011 SHALL have ports rsp_target and rsp_link, each output, XLEN.
REQ-012 SHALL have port rsp_misalign, output, 1.
REQ-013 SHALL have port taken_cnt, output, 32, a count of taken responses.

Function
REQ-014 SHALL map funct3 to comparator ops as: 000 EQ, 001 NE, 100 LT (signed), 101 GE (signed), 110 LTU, 111 GEU; 010 and 011 SHALL resolve not-taken.
REQ-015 SHALL use op ONE (always taken) for JAL and JALR, and SHALL resolve reserved kind as not-taken.
REQ-016 SHALL compute target as pc+imm for BRANCH and JAL, and as (rs1+imm) with bit 0 cleared for JALR, all modulo 2^XLEN.
REQ-017 SHALL compute link as pc+4, modulo 2^XLEN.
REQ-018 SHALL be a one-entry pipeline with FSM states EMPTY and FULL; rsp_valid SHALL equal (state==FULL).
REQ-019 SHALL drive req_ready = !flush && (EMPTY || rsp_ready).
REQ-020 SHALL register the result of a request accepted in cycle N so that rsp_valid is high in cycle N+1, giving a latency of one cycle.
REQ-021 SHALL hold rsp_* stable while rsp_valid && !rsp_ready.
REQ-022 SHALL, on an accept with no response handshake, transition EMPTY->FULL.
REQ-023 SHALL, on a response handshake with no accept, transition FULL->EMPTY.
REQ-024 SHALL, on a response handshake and an accept in the same cycle, stay FULL and load the new result.
REQ-025 SHALL give flush priority over both: next state EMPTY, no accept, and the held result discarded without counting.
REQ-026 SHALL increment taken_cnt by 1 on each response handshake with rsp_taken=1, wrapping from 0xFFFFFFFF to 0.

Reset
REQ-027 SHALL, while rst_n is low and regardless of clk: state=EMPTY, rsp_valid=0, rsp_taken=0, rsp_target=0, rsp_link=0, rsp_misalign=0, taken_cnt=0.
REQ-028 SHALL drop an in-flight result on reset asserted mid-operation, with no partial update.

Configuration
REQ-029 SHALL, with macro BRANCH_RESOLVE_MISALIGN_EN defined, set rsp_misalign = rsp_taken && target[1]; a misaligned response still presents the computed target, and it is not counted in taken_cnt.
REQ-030 SHALL, without BRANCH_RESOLVE_MISALIGN_EN, tie rsp_misalign to 0 and count every taken response.

Structure
REQ-031 SHALL take COM_OP_* encodings and the register width from the shared defines, and SHALL add the req_kind encodings there.
REQ-032 SHALL instantiate the existing com comparator as its sole sub-module, driven combinationally from the request operands.

Verification
REQ-033 SHALL cover: BRANCH, funct3=000, rs1=rs2=5, pc=0x100, imm=0x20 -> next cycle rsp_taken=1, target=0x120, link=0x104.
REQ-034 SHALL cover: BRANCH, funct3=100, rs1=0xFFFFFFFF, rs2=1 -> taken=1; same operands with funct3=110 -> taken=0.
REQ-035 SHALL cover: JALR, rs1=0x1001, imm=0x4 -> taken=1, target=0x1004; with the macro defined, rs1=0x1002, imm=0 -> misalign=1 and taken_cnt unchanged.
REQ-036 SHALL cover: rsp_ready held low for 3 cycles -> rsp_* stable, req_ready=0; then rsp_ready=1 with req_valid=1 -> back-to-back results, state remains FULL.
REQ-037 SHALL cover: flush while FULL with req_valid=1 -> req_ready=0, next cycle rsp_valid=0, taken_cnt unchanged; funct3=010 -> taken=0.
REQ-038 SHALL cover: taken_cnt preloaded via 0xFFFFFFFF taken handshakes, or forced -> next taken wraps to 0; rst_n low mid-FULL -> immediate rsp_valid=0.
